// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue controller: ALU op codes, RISC-V funct3 values,
// FSM state type and the registered response payload.
package alu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [OP_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [OP_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [OP_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'b1001;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'b1100;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'b1101;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'b1110;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'b1111;

  localparam logic [F3_W-1:0] F3_ADD  = 3'b000;
  localparam logic [F3_W-1:0] F3_SLL  = 3'b001;
  localparam logic [F3_W-1:0] F3_SLT  = 3'b010;
  localparam logic [F3_W-1:0] F3_SLTU = 3'b011;
  localparam logic [F3_W-1:0] F3_XOR  = 3'b100;
  localparam logic [F3_W-1:0] F3_SR   = 3'b101;
  localparam logic [F3_W-1:0] F3_OR   = 3'b110;
  localparam logic [F3_W-1:0] F3_AND  = 3'b111;

  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            zero;
    logic            taken;
    logic            illegal;
  } rsp_t;

  // Branch outcome from the compare result: EQ/NE look at zero, LT/GE at the SLT(U) bit.
  function automatic logic branch_taken(input logic [F3_W-1:0] funct3,
                                        input logic            res0,
                                        input logic            zero);
    logic taken;
    taken = 1'b0;
    case (funct3)
      F3_BEQ:           taken = zero;
      F3_BNE:           taken = !zero;
      F3_BLT, F3_BLTU:  taken = res0;
      F3_BGE, F3_BGEU:  taken = !res0;
      default:          taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of RISC-V arithmetic/branch fields into an ALU op code,
// a shift flag (for operand B masking) and an illegal-branch flag.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [F3_W-1:0] funct3,
  input  logic            funct7b5,
  input  logic            is_imm,
  input  logic            is_branch,
  output logic [OP_W-1:0] alu_op_c,
  output logic            is_shift_c,
  output logic            illegal_c
);

  always_comb begin
    alu_op_c   = ALU_ADD;
    is_shift_c = 1'b0;
    illegal_c  = 1'b0;
    if (is_branch) begin
      case (funct3)
        F3_BEQ, F3_BNE:   alu_op_c = ALU_SUB;
        F3_BLT, F3_BGE:   alu_op_c = ALU_SLT;
        F3_BLTU, F3_BGEU: alu_op_c = ALU_SLTU;
        default: begin
          alu_op_c  = ALU_ADD;
          illegal_c = 1'b1;
        end
      endcase
    end else begin
      case (funct3)
        F3_ADD:  alu_op_c = (!is_imm && funct7b5) ? ALU_SUB : ALU_ADD;
        F3_SLL: begin
          alu_op_c   = ALU_SLL;
          is_shift_c = 1'b1;
        end
        F3_SLT:  alu_op_c = ALU_SLT;
        F3_SLTU: alu_op_c = ALU_SLTU;
        F3_XOR:  alu_op_c = ALU_XOR;
        // funct7b5 selects arithmetic shift for both R- and I-type forms
        F3_SR: begin
          alu_op_c   = funct7b5 ? ALU_SRA : ALU_SRL;
          is_shift_c = 1'b1;
        end
        F3_OR:   alu_op_c = ALU_OR;
        F3_AND:  alu_op_c = ALU_AND;
        default: alu_op_c = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-outstanding issue controller: accepts a request, drives registered operands
// to an external combinational ALU for one cycle, then holds the response until taken.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [F3_W-1:0] req_funct3,
  input  logic            req_funct7b5,
  input  logic            req_is_imm,
  input  logic            req_is_branch,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic [XLEN-1:0] alu_A,
  output logic [XLEN-1:0] alu_B,
  output logic [OP_W-1:0] alu_op,
  input  logic [XLEN-1:0] alu_res,
  input  logic            alu_zero,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_res,
  output logic            rsp_zero,
  output logic            rsp_taken,
  output logic            rsp_illegal
);

  state_e          state_q, state_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  rsp_t            rsp_q, rsp_d;
  logic [XLEN-1:0] alu_a_q, alu_a_d;
  logic [XLEN-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0] alu_op_q, alu_op_d;
  logic [F3_W-1:0] funct3_q, funct3_d;
  logic            branch_q, branch_d;
  logic            illegal_q, illegal_d;

  logic [OP_W-1:0] dec_op_c;
  logic            dec_shift_c;
  logic            dec_illegal_c;

  alu_op_decode u_decode (
    .funct3     (req_funct3),
    .funct7b5   (req_funct7b5),
    .is_imm     (req_is_imm),
    .is_branch  (req_is_branch),
    .alu_op_c   (dec_op_c),
    .is_shift_c (dec_shift_c),
    .illegal_c  (dec_illegal_c)
  );

  // Next-state and next-register values
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    funct3_d    = funct3_q;
    branch_d    = branch_q;
    illegal_d   = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d   = ST_EXEC;
          alu_a_d   = req_a;
          alu_b_d   = dec_shift_c ? XLEN'(req_b[SHAMT_W-1:0]) : req_b;
          alu_op_d  = dec_op_c;
          funct3_d  = req_funct3;
          branch_d  = req_is_branch;
          illegal_d = dec_illegal_c;
        end
      end
      ST_EXEC: begin
        state_d       = ST_RESP;
        rsp_valid_d   = 1'b1;
        rsp_d.res     = alu_res;
        rsp_d.zero    = alu_zero;
        rsp_d.taken   = branch_q && !illegal_q && branch_taken(funct3_q, alu_res[0], alu_zero);
        rsp_d.illegal = illegal_q;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; ready is a flop so it stays low through reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= ALU_ADD;
      funct3_q    <= '0;
      branch_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      funct3_q    <= funct3_d;
      branch_q    <= branch_d;
      illegal_q   <= illegal_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_res     = rsp_q.res;
  assign rsp_zero    = rsp_q.zero;
  assign rsp_taken   = rsp_q.taken;
  assign rsp_illegal = rsp_q.illegal;
  assign alu_A       = alu_a_q;
  assign alu_B       = alu_b_q;
  assign alu_op      = alu_op_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and a scoreboard of
// expected responses computed from the request fields.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic        req_funct7b5;
  logic        req_is_imm;
  logic        req_is_branch;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [3:0]  alu_op;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_res;
  logic        rsp_zero;
  logic        rsp_taken;
  logic        rsp_illegal;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] bval;
    logic [31:0] res;
    logic        zero;
    logic        taken;
    logic        illegal;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_hs     = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_funct3    (req_funct3),
    .req_funct7b5  (req_funct7b5),
    .req_is_imm    (req_is_imm),
    .req_is_branch (req_is_branch),
    .req_a         (req_a),
    .req_b         (req_b),
    .alu_A         (alu_A),
    .alu_B         (alu_B),
    .alu_op        (alu_op),
    .alu_res       (alu_res),
    .alu_zero      (alu_zero),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_res       (rsp_res),
    .rsp_zero      (rsp_zero),
    .rsp_taken     (rsp_taken),
    .rsp_illegal   (rsp_illegal)
  );

  // Behavioural ALU keyed on the op code
  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'b0000: alu_res = alu_A & alu_B;
      4'b0001: alu_res = alu_A | alu_B;
      4'b0010: alu_res = alu_A + alu_B;
      4'b0110: alu_res = alu_A - alu_B;
      4'b0111: alu_res = {31'b0, $signed(alu_A) < $signed(alu_B)};
      4'b1001: alu_res = {31'b0, alu_A < alu_B};
      4'b1100: alu_res = alu_A ^ alu_B;
      4'b1101: alu_res = 32'($signed(alu_A) >>> alu_B[4:0]);
      4'b1110: alu_res = alu_A << alu_B[4:0];
      4'b1111: alu_res = alu_A >> alu_B[4:0];
      default: alu_res = '0;
    endcase
    alu_zero = (alu_res == 32'd0);
  end

  always @(posedge clk) if (rsp_valid && rsp_ready) n_hs <= n_hs + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: instruction semantics computed directly from the request
  function automatic exp_t calc(input logic [2:0] f3, input logic f7, input logic imm,
                                input logic br, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic slt, sltu;
    slt  = $signed(a) < $signed(b);
    sltu = a < b;
    e.bval = b; e.taken = 1'b0; e.illegal = 1'b0; e.op = 4'b0010; e.res = a + b;
    if (br) begin
      case (f3)
        3'b000: begin e.op = 4'b0110; e.res = a - b; e.taken = (a == b); end
        3'b001: begin e.op = 4'b0110; e.res = a - b; e.taken = (a != b); end
        3'b100: begin e.op = 4'b0111; e.res = {31'b0, slt};  e.taken = slt;   end
        3'b101: begin e.op = 4'b0111; e.res = {31'b0, slt};  e.taken = !slt;  end
        3'b110: begin e.op = 4'b1001; e.res = {31'b0, sltu}; e.taken = sltu;  end
        3'b111: begin e.op = 4'b1001; e.res = {31'b0, sltu}; e.taken = !sltu; end
        default: e.illegal = 1'b1;
      endcase
    end else begin
      case (f3)
        3'b000: if (!imm && f7) begin e.op = 4'b0110; e.res = a - b; end
        3'b001: begin e.op = 4'b1110; e.bval = {27'b0, b[4:0]}; e.res = a << b[4:0]; end
        3'b010: begin e.op = 4'b0111; e.res = {31'b0, slt}; end
        3'b011: begin e.op = 4'b1001; e.res = {31'b0, sltu}; end
        3'b100: begin e.op = 4'b1100; e.res = a ^ b; end
        3'b101: begin
          e.bval = {27'b0, b[4:0]};
          if (f7) begin e.op = 4'b1101; e.res = 32'($signed(a) >>> b[4:0]); end
          else    begin e.op = 4'b1111; e.res = a >> b[4:0]; end
        end
        3'b110: begin e.op = 4'b0001; e.res = a | b; end
        default: begin e.op = 4'b0000; e.res = a & b; end
      endcase
    end
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // One operation from an IDLE negedge back to the next IDLE negedge
  task automatic run_op(input string nm, input logic [2:0] f3, input logic f7, input logic imm,
                        input logic br, input logic [31:0] a, input logic [31:0] b, input int stall);
    exp_t e;
    exp_t got;
    int   hs0;
    logic [31:0] snap_res;
    logic [3:0]  snap_flags;
    e = calc(f3, f7, imm, br, a, b);
    check({nm, ".req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_funct3 = f3; req_funct7b5 = f7; req_is_imm = imm;
    req_is_branch = br; req_a = a; req_b = b;
    rsp_ready = (stall == 0);
    sb.push_back(e);
    hs0 = n_hs;
    @(negedge clk);
    // EXEC: new requests must be ignored, so keep offering different data
    req_a = ~a; req_b = ~b;
    check({nm, ".exec_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({nm, ".exec_req_ready"}, 32'(req_ready), 32'd0);
    check({nm, ".alu_A"}, alu_A, a);
    check({nm, ".alu_B"}, alu_B, e.bval);
    check({nm, ".alu_op"}, 32'(alu_op), 32'(e.op));
    @(negedge clk);
    check({nm, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({nm, ".sb_nonempty"}, 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      got = sb.pop_front();
      check({nm, ".rsp_res"}, rsp_res, got.res);
      check({nm, ".rsp_zero"}, 32'(rsp_zero), 32'(got.zero));
      check({nm, ".rsp_taken"}, 32'(rsp_taken), 32'(got.taken));
      check({nm, ".rsp_illegal"}, 32'(rsp_illegal), 32'(got.illegal));
    end
    snap_res   = rsp_res;
    snap_flags = {rsp_zero, rsp_taken, rsp_illegal, 1'b0};
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({nm, ".bp_rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({nm, ".bp_req_ready"}, 32'(req_ready), 32'd0);
      check({nm, ".bp_res"}, rsp_res, snap_res);
      check({nm, ".bp_flags"}, 32'({rsp_zero, rsp_taken, rsp_illegal, 1'b0}), 32'(snap_flags));
      check({nm, ".bp_alu_A"}, alu_A, a);
      check({nm, ".bp_alu_op"}, 32'(alu_op), 32'(e.op));
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check({nm, ".done_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({nm, ".done_req_ready"}, 32'(req_ready), 32'd1);
    check({nm, ".handshakes"}, 32'(n_hs - hs0), 32'd1);
  endtask

  initial begin
    int hs_before;
    rst_n = 1'b0; req_valid = 1'b0; req_funct3 = '0; req_funct7b5 = 1'b0;
    req_is_imm = 1'b0; req_is_branch = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.req_ready", 32'(req_ready), 32'd0);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_res", rsp_res, 32'd0);
    check("rst.rsp_flags", 32'({rsp_zero, rsp_taken, rsp_illegal}), 32'd0);
    check("rst.alu_A", alu_A, 32'd0);
    check("rst.alu_B", alu_B, 32'd0);
    check("rst.alu_op", 32'(alu_op), 32'h2);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel.req_ready", 32'(req_ready), 32'd1);

    run_op("add",      3'b000, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, 0);
    run_op("sub",      3'b000, 1'b1, 1'b0, 1'b0, 32'd10, 32'd10, 0);
    run_op("addi_f7",  3'b000, 1'b1, 1'b1, 1'b0, 32'd10, 32'd3, 0);
    run_op("sll",      3'b001, 1'b0, 1'b0, 1'b0, 32'h0000_0003, 32'hFFFF_FFE4, 0);
    run_op("slt",      3'b010, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'd2, 0);
    run_op("sltu",     3'b011, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'd2, 0);
    run_op("xor",      3'b100, 1'b0, 1'b0, 1'b0, 32'hA5A5_0F0F, 32'hFFFF_0000, 0);
    run_op("srl",      3'b101, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd31, 0);
    run_op("srai",     3'b101, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_0404, 0);
    run_op("or",       3'b110, 1'b0, 1'b1, 1'b0, 32'h1200_0034, 32'h0056_0000, 0);
    run_op("and",      3'b111, 1'b0, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 0);
    run_op("beq",      3'b000, 1'b0, 1'b0, 1'b1, 32'd9, 32'd9, 0);
    run_op("bne",      3'b001, 1'b0, 1'b0, 1'b1, 32'd9, 32'd9, 0);
    run_op("blt",      3'b100, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("bltu",     3'b110, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("bge",      3'b101, 1'b0, 1'b0, 1'b1, 32'd4, 32'd4, 0);
    run_op("bgeu",     3'b111, 1'b0, 1'b0, 1'b1, 32'd1, 32'd2, 0);
    run_op("ill_011",  3'b011, 1'b0, 1'b0, 1'b1, 32'd3, 32'd4, 0);
    run_op("ill_010",  3'b010, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("bp_sub",   3'b000, 1'b1, 1'b0, 1'b0, 32'd100, 32'd58, 5);

    // Reset while in EXEC: operation dropped, no response
    hs_before = n_hs;
    req_valid = 1'b1; req_funct3 = 3'b000; req_funct7b5 = 1'b0; req_is_imm = 1'b0;
    req_is_branch = 1'b0; req_a = 32'd21; req_b = 32'd21;
    @(negedge clk);
    check("rexec.in_exec", 32'(req_ready), 32'd0);
    rst_n = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("rexec.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rexec.req_ready_low", 32'(req_ready), 32'd0);
    check("rexec.alu_op", 32'(alu_op), 32'h2);
    check("rexec.alu_A", alu_A, 32'd0);
    check("rexec.rsp_res", rsp_res, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rexec.req_ready_rel", 32'(req_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("rexec.no_rsp", 32'(rsp_valid), 32'd0);
    end
    check("rexec.handshakes", 32'(n_hs - hs_before), 32'd0);

    run_op("post_rst", 3'b000, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, 0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
